// File: rtl/useq_pkg.sv
// Shared microsequencer definitions: control-word field positions, N-field
// encodings, fault codes and default reset/fault microstates. The control-store
// ROM image and the instruction decoder use the same field positions.
package useq_pkg;
    localparam int N_HI    = 57;
    localparam int N_LO    = 55;
    localparam int INV_BIT = 54;
    localparam int S_HI    = 52;
    localparam int S_LO    = 50;
    localparam int CR_HI   = 49;
    localparam int CR_LO   = 42;

    localparam logic [7:0] RESET_ADDR_DEF = 8'd0;
    localparam logic [7:0] FAULT_ADDR_DEF = 8'd255;

    typedef enum logic [2:0] {
        N_ENC  = 3'd0,
        N_INC  = 3'd1,
        N_JMP  = 3'd2,
        N_CJ   = 3'd3,
        N_WAIT = 3'd4,
        N_CALL = 3'd5,
        N_RET  = 3'd6,
        N_CRET = 3'd7
    } nfield_t;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_OVF  = 2'd1,
        FC_UNF  = 2'd2,
        FC_TMO  = 2'd3
    } fcode_t;

    typedef struct packed {
        nfield_t    n;
        logic       inv;
        logic [2:0] s;
        logic [7:0] cr;
    } ufields_t;

    function automatic ufields_t get_fields(input logic [63:0] w);
        ufields_t f;
        f.n   = nfield_t'(w[N_HI:N_LO]);
        f.inv = w[INV_BIT];
        f.s   = w[S_HI:S_LO];
        f.cr  = w[CR_HI:CR_LO];
        return f;
    endfunction
endpackage

// File: rtl/microsequencer_ustack.sv
// Return-address LIFO for micro-subroutines.
// Ports: clk/reset (async high), push/pop (never both), din = address to push,
// top = most recently pushed entry (valid when !empty), full/empty flags.
// Pushes while full and pops while empty are ignored.
module ustack #(
    parameter int DEPTH = 4,   // 1..8
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    logic [3:0]   sp;
    // Storage sized for the maximum depth; only DEPTH entries are ever written.
    logic [W-1:0] mem [0:7];

    assign full  = (sp == 4'(DEPTH));
    assign empty = (sp == 4'd0);
    // sp==8 wraps the 3-bit index to 0, so 0-1 lands correctly on entry 7.
    assign top   = mem[3'(sp[2:0] - 3'd1)];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sp <= 4'd0;
        else if (push && !full)
            sp <= sp + 4'd1;
        else if (pop && !empty)
            sp <= sp - 4'd1;
    end

    // Contents need no reset: sp==0 makes every stale entry unreachable.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[2:0]] <= din;
    end
endmodule

// File: rtl/microsequencer.sv
// Control-store next-address sequencer.
// Holds the current microstate (rom_addr_o), decodes N/INV/S/CR of the
// returned ROM word to select the next state, and passes the word to the
// datapath as ctrl_o (zeroed while stalled). Includes a return stack,
// bounded WAIT with timeout, and sticky fault reporting.
// Ports: clk, reset (async high), rom_word_i, rom_addr_o, decode_addr_i,
// cond_i (S-selected condition lines), stall_i, ctrl_o, fault_o, fault_code_o.
module microsequencer
    import useq_pkg::*;
#(
    parameter logic [7:0] RESET_ADDR  = RESET_ADDR_DEF,
    parameter logic [7:0] FAULT_ADDR  = FAULT_ADDR_DEF,
    parameter int         STACK_DEPTH = 4,
    parameter int         WAIT_MAX    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] rom_word_i,
    output logic [7:0]  rom_addr_o,
    input  logic [7:0]  decode_addr_i,
    input  logic [7:0]  cond_i,
    input  logic        stall_i,
    output logic [63:0] ctrl_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o
);
    localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    ufields_t       f;
    logic           c;
    logic [7:0]     inc, nxt;
    logic           push, pop, wait_hold, flt;
    fcode_t         flt_code;
    logic [7:0]     stk_top;
    logic           stk_full, stk_empty;
    logic [WCW-1:0] wait_cnt;

    assign f      = get_fields(rom_word_i);
    assign c      = ((f.s == 3'd0) ? 1'b1 : cond_i[f.s]) ^ f.inv;
    assign inc    = rom_addr_o + 8'd1;
    assign ctrl_o = stall_i ? 64'd0 : rom_word_i;

    always_comb begin
        nxt       = rom_addr_o;
        push      = 1'b0;
        pop       = 1'b0;
        wait_hold = 1'b0;
        flt       = 1'b0;
        flt_code  = FC_NONE;
        unique case (f.n)
            N_ENC:  nxt = decode_addr_i;
            N_INC:  nxt = inc;
            N_JMP:  nxt = f.cr;
            N_CJ:   nxt = c ? f.cr : inc;
            N_WAIT: begin
                if (c)
                    nxt = inc;
                else if (WAIT_MAX > 0 && wait_cnt == WLAST) begin
                    nxt      = FAULT_ADDR;
                    flt      = 1'b1;
                    flt_code = FC_TMO;
                end else
                    wait_hold = 1'b1;
            end
            N_CALL: begin
                if (stk_full) begin
                    nxt      = FAULT_ADDR;
                    flt      = 1'b1;
                    flt_code = FC_OVF;
                end else begin
                    push = 1'b1;
                    nxt  = f.cr;
                end
            end
            N_RET, N_CRET: begin
                if (f.n == N_CRET && !c)
                    nxt = inc;
                else if (stk_empty) begin
                    nxt      = FAULT_ADDR;
                    flt      = 1'b1;
                    flt_code = FC_UNF;
                end else begin
                    pop = 1'b1;
                    nxt = stk_top;
                end
            end
            default: nxt = inc;
        endcase
    end

    ustack #(.DEPTH(STACK_DEPTH), .W(8)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push && !stall_i),
        .pop   (pop && !stall_i),
        .din   (inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_o   <= RESET_ADDR;
            wait_cnt     <= '0;
            fault_o      <= 1'b0;
            fault_code_o <= 2'd0;
        end else if (!stall_i) begin
            rom_addr_o <= nxt;
            // Any transition out of WAIT (advance or timeout) restarts the count.
            wait_cnt   <= wait_hold ? wait_cnt + 1'b1 : '0;
            if (flt) begin
                fault_o <= 1'b1;
                // First fault's cause is preserved.
                if (!fault_o)
                    fault_code_o <= flt_code;
            end
        end
    end
endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rom_word;
    logic [7:0]  rom_addr;
    logic [7:0]  decode_addr = 8'd0;
    logic [7:0]  cond = 8'd0;
    logic        stall = 1'b0;
    logic [63:0] ctrl;
    logic        fault;
    logic [1:0]  fault_code;

    logic [63:0] rom [0:255];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    assign rom_word = rom[rom_addr];

    microsequencer dut (
        .clk(clk), .reset(reset), .rom_word_i(rom_word), .rom_addr_o(rom_addr),
        .decode_addr_i(decode_addr), .cond_i(cond), .stall_i(stall),
        .ctrl_o(ctrl), .fault_o(fault), .fault_code_o(fault_code)
    );

    localparam logic [2:0] ENC = 3'd0, INC = 3'd1, JMP = 3'd2, CJ = 3'd3,
                           WAIT = 3'd4, CALL = 3'd5, RET = 3'd6, CRET = 3'd7;

    function automatic logic [63:0] mk(input logic [2:0] n, input logic inv,
                                       input logic [2:0] s, input logic [7:0] cr);
        logic [63:0] w;
        w        = 64'h0000_0000_0000_00A5;   // nonzero datapath bits
        w[57:55] = n;
        w[54]    = inv;
        w[52:50] = s;
        w[49:42] = cr;
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic go_to(input logic [7:0] a);
        do_reset();
        rom[0] = mk(JMP, 1'b0, 3'd0, a);
        tick();
    endtask

    typedef struct {
        logic [7:0] start;
        logic [2:0] n;
        logic       inv;
        logic [2:0] s;
        logic [7:0] cr;
        logic [7:0] cond;
        logic [7:0] dec;
        logic [7:0] exp_addr;
        logic       exp_fault;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [13];

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = mk(INC, 1'b0, 3'd0, 8'd0);

        vecs[0]  = '{8'd3,   ENC,  1'b0, 3'd0, 8'd0,   8'h00, 8'd10, 8'd10,  1'b0, 2'd0};
        vecs[1]  = '{8'd5,   CJ,   1'b0, 3'd2, 8'd77,  8'h00, 8'd0,  8'd6,   1'b0, 2'd0};
        vecs[2]  = '{8'd5,   CJ,   1'b1, 3'd2, 8'd77,  8'h00, 8'd0,  8'd77,  1'b0, 2'd0};
        vecs[3]  = '{8'd255, INC,  1'b0, 3'd0, 8'd0,   8'h00, 8'd0,  8'd0,   1'b0, 2'd0};
        vecs[4]  = '{8'd9,   JMP,  1'b0, 3'd0, 8'd200, 8'h00, 8'd0,  8'd200, 1'b0, 2'd0};
        vecs[5]  = '{8'd7,   CJ,   1'b0, 3'd0, 8'd33,  8'h00, 8'd0,  8'd33,  1'b0, 2'd0};
        vecs[6]  = '{8'd8,   WAIT, 1'b0, 3'd1, 8'd0,   8'h02, 8'd0,  8'd9,   1'b0, 2'd0};
        vecs[7]  = '{8'd8,   WAIT, 1'b0, 3'd1, 8'd0,   8'h00, 8'd0,  8'd8,   1'b0, 2'd0};
        vecs[8]  = '{8'd12,  RET,  1'b0, 3'd0, 8'd0,   8'h00, 8'd0,  8'd255, 1'b1, 2'd2};
        vecs[9]  = '{8'd14,  CRET, 1'b0, 3'd3, 8'd0,   8'h08, 8'd0,  8'd255, 1'b1, 2'd2};
        vecs[10] = '{8'd14,  CRET, 1'b0, 3'd3, 8'd0,   8'h00, 8'd0,  8'd15,  1'b0, 2'd0};
        vecs[11] = '{8'd20,  CALL, 1'b0, 3'd0, 8'd40,  8'h00, 8'd0,  8'd40,  1'b0, 2'd0};
        vecs[12] = '{8'd30,  WAIT, 1'b1, 3'd1, 8'd0,   8'h02, 8'd0,  8'd30,  1'b0, 2'd0};

        // Reset state and straight-line INC
        #1;
        chk("reset_addr", 64'(rom_addr), 64'd0);
        chk("reset_fault", 64'(fault), 64'd0);
        chk("reset_code", 64'(fault_code), 64'd0);
        do_reset();
        chk("unstalled_ctrl", ctrl, rom[0]);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("inc_seq_%0d", i), 64'(rom_addr), 64'(i));
        end

        // Single-transition vectors
        for (int i = 0; i < 13; i++) begin
            go_to(vecs[i].start);
            rom[vecs[i].start] = mk(vecs[i].n, vecs[i].inv, vecs[i].s, vecs[i].cr);
            cond = vecs[i].cond;
            decode_addr = vecs[i].dec;
            tick();
            chk($sformatf("vec%0d_addr", i), 64'(rom_addr), 64'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_fault", i), 64'(fault), 64'(vecs[i].exp_fault));
            chk($sformatf("vec%0d_code", i), 64'(fault_code), 64'(vecs[i].exp_code));
            cond = 8'd0;
            decode_addr = 8'd0;
        end

        // WAIT on MOC: held three cycles, then advance
        rom[50] = mk(WAIT, 1'b0, 3'd1, 8'd0);
        rom[51] = mk(JMP, 1'b0, 3'd0, 8'd51);
        go_to(8'd50);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wait_hold_%0d", i), 64'(rom_addr), 64'd50);
        end
        cond = 8'h02;
        tick();
        chk("wait_release", 64'(rom_addr), 64'd51);
        cond = 8'd0;

        // CALL / RET
        rom[20] = mk(CALL, 1'b0, 3'd0, 8'd40);
        rom[40] = mk(RET, 1'b0, 3'd0, 8'd0);
        rom[21] = mk(JMP, 1'b0, 3'd0, 8'd21);
        go_to(8'd20);
        tick();
        chk("call_target", 64'(rom_addr), 64'd40);
        tick();
        chk("ret_target", 64'(rom_addr), 64'd21);
        chk("call_ret_nofault", 64'(fault), 64'd0);

        // Nested calls: four fit, fifth overflows
        for (int i = 60; i <= 64; i++) rom[i] = mk(CALL, 1'b0, 3'd0, 8'(i + 1));
        rom[255] = mk(JMP, 1'b0, 3'd0, 8'd255);
        go_to(8'd60);
        for (int i = 61; i <= 64; i++) begin
            tick();
            chk($sformatf("nest_%0d", i), 64'(rom_addr), 64'(i));
        end
        chk("nest_depth4_nofault", 64'(fault), 64'd0);
        tick();
        chk("overflow_addr", 64'(rom_addr), 64'd255);
        chk("overflow_code", 64'(fault_code), 64'd1);
        chk("overflow_fault", 64'(fault), 64'd1);

        // Stall across CALL and WAIT; stack must see exactly one push
        rom[70] = mk(CALL, 1'b0, 3'd0, 8'd80);
        rom[80] = mk(WAIT, 1'b0, 3'd1, 8'd0);
        rom[81] = mk(RET, 1'b0, 3'd0, 8'd0);
        rom[71] = mk(RET, 1'b0, 3'd0, 8'd0);
        go_to(8'd70);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_call_addr_%0d", i), 64'(rom_addr), 64'd70);
            chk($sformatf("stall_call_ctrl_%0d", i), ctrl, 64'd0);
        end
        stall = 1'b0;
        tick();
        chk("post_stall_call", 64'(rom_addr), 64'd80);
        tick();
        chk("wait_before_stall", 64'(rom_addr), 64'd80);
        stall = 1'b1;
        cond = 8'h02;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_wait_addr_%0d", i), 64'(rom_addr), 64'd80);
        end
        stall = 1'b0;
        tick();
        chk("post_stall_wait", 64'(rom_addr), 64'd81);
        tick();
        chk("post_stall_ret", 64'(rom_addr), 64'd71);
        tick();
        chk("single_push_underflow", 64'(rom_addr), 64'd255);
        chk("single_push_code", 64'(fault_code), 64'd2);
        cond = 8'd0;

        // Timeout after 16 unstalled cycles; stall must freeze the counter
        // and cond_i must be ignored while stalled.
        go_to(8'd50);
        for (int i = 0; i < 2; i++) tick();
        stall = 1'b1;
        cond = 8'h02;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_freeze_addr", 64'(rom_addr), 64'd50);
        stall = 1'b0;
        cond = 8'd0;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("tmo_hold_%0d", i), 64'(rom_addr), 64'd50);
        end
        tick();
        chk("tmo_addr", 64'(rom_addr), 64'd255);
        chk("tmo_code", 64'(fault_code), 64'd3);
        chk("tmo_fault", 64'(fault), 64'd1);

        // Reset mid-WAIT with two return addresses stacked, fault already set
        rom[255] = mk(JMP, 1'b0, 3'd0, 8'd90);
        rom[90]  = mk(CALL, 1'b0, 3'd0, 8'd91);
        rom[91]  = mk(CALL, 1'b0, 3'd0, 8'd92);
        rom[92]  = mk(WAIT, 1'b0, 3'd1, 8'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_addr", 64'(rom_addr), 64'd92);
        chk("pre_reset_fault", 64'(fault), 64'd1);
        rom[0] = mk(RET, 1'b0, 3'd0, 8'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_addr", 64'(rom_addr), 64'd0);
        chk("async_reset_fault", 64'(fault), 64'd0);
        chk("async_reset_code", 64'(fault_code), 64'd0);
        reset = 1'b0;
        tick();
        chk("ret_after_reset_addr", 64'(rom_addr), 64'd255);
        chk("ret_after_reset_code", 64'(fault_code), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
